fir_decim_fifo: RTL and testbench

Output stage directly downstream of the hcub FIR filter. It consumes the filter's signed 10-bit output, one sample per clock. Samples are decimated by accumulate-and-dump, rounded, scaled and saturated to a narrower word, then buffered in a small FIFO with a valid/ready interface toward the consumer (DAC/UART packer). The clr input lets the bench or controller flush the stage whenever the filter itself is reset.

---
 rtl/fir_decim_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_fir_decim_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_fifo.sv
// -----------------------------------------------------------------------------
// fir_decim_fifo
//
// Output stage that sits right after the hcub FIR filter. Incoming samples
// are decimated by accumulate-and-dump. Each dumped sum is rounded
// (round-half-up), arithmetically shifted, saturated to OUT_W bits, and then
// queued in a small first-word-fall-through FIFO. The FIFO feeds the
// consumer through a valid/ready handshake.
//
// Parameters:
//   IN_W       width of the signed input sample
//   OUT_W      width of the signed output word
//   DECIM      decimation factor (>= 2)
//   SHIFT      arithmetic right shift after accumulation (0 = no shift/round)
//   FIFO_DEPTH output FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   y_in       signed sample from the filter
//   en         y_in is valid this cycle
//   clr        synchronous flush of accumulator, phase, FIFO and ovf
//   m_data     signed FIFO head word (combinational from the read pointer)
//   m_valid    FIFO is non-empty
//   m_ready    consumer accepts m_data this cycle
//   fifo_level current number of FIFO entries
//   ovf        sticky flag: a dump was dropped because the FIFO was full
//   sat_cnt    (FIR_DECIM_SATCNT_EN only) saturating count of clipped dumps
//
// Optional feature macro: FIR_DECIM_SATCNT_EN adds the sat_cnt port and its
// counter. When the macro is undefined, the port and the counter are absent.
// -----------------------------------------------------------------------------
module fir_decim_fifo #(
    parameter int IN_W       = 10,
    parameter int OUT_W      = 8,
    parameter int DECIM      = 4,
    parameter int SHIFT      = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  y_in,
    input  logic                    en,
    input  logic                    clr,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LVL_W-1:0]        fifo_level,
    output logic                    ovf
`ifdef FIR_DECIM_SATCNT_EN
    ,
    output logic [15:0]             sat_cnt
`endif
);

    localparam int ACC_W = IN_W + $clog2(DECIM) + 1;
    localparam int PH_W  = $clog2(DECIM);
    localparam int AW    = $clog2(FIFO_DEPTH);
    // One extra bit so that adding the rounding constant cannot wrap.
    localparam int RW    = ACC_W + 1;

    localparam logic [PH_W-1:0]       LAST_PHASE = PH_W'(DECIM - 1);
    localparam logic signed [RW-1:0]  SAT_MAX    = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0]  SAT_MIN    = RW'(-(1 << (OUT_W - 1)));
    localparam logic [LVL_W-1:0]      FULL_LVL   = LVL_W'(FIFO_DEPTH);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic        [PH_W-1:0]  phase;
    logic                    dump;

    logic signed [RW-1:0]    sum_ext;
    logic signed [RW-1:0]    rounded;
    logic signed [OUT_W-1:0] sat_word;
    logic                    clipped;

    logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [LVL_W-1:0]        level;
    logic                    full;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;

    // Running sum including the current sample. On a dump cycle this value
    // is the complete block total.
    assign sum     = acc + {{(ACC_W - IN_W){y_in[IN_W-1]}}, y_in};
    assign dump    = en && (phase == LAST_PHASE);
    assign sum_ext = {sum[ACC_W-1], sum};

    // Round-half-up: add half an LSB of the shifted result, then shift
    // arithmetically. This rounds toward +inf on exact ties.
    generate
        if (SHIFT == 0) begin : g_no_shift
            assign rounded = sum_ext;
        end else begin : g_shift
            localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
            assign rounded = (sum_ext + HALF) >>> SHIFT;
        end
    endgenerate

    // Clamp the rounded value into the signed OUT_W range. Also flag when
    // clipping happened so the saturation counter can see it.
    always_comb begin
        clipped  = 1'b0;
        sat_word = rounded[OUT_W-1:0];
        if (rounded > SAT_MAX) begin
            sat_word = SAT_MAX[OUT_W-1:0];
            clipped  = 1'b1;
        end else if (rounded < SAT_MIN) begin
            sat_word = SAT_MIN[OUT_W-1:0];
            clipped  = 1'b1;
        end
    end

    // Accumulate-and-dump state. The dump cycle does not store the sum; it
    // restarts the block from zero. The word is pushed to the FIFO instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            phase <= '0;
        end else if (clr) begin
            acc   <= '0;
            phase <= '0;
        end else if (en) begin
            if (phase == LAST_PHASE) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum;
                phase <= phase + 1'b1;
            end
        end
    end

    // FIFO handshake. A push into a full FIFO is still accepted when the
    // head is popped in the same cycle. The slot being freed is the one
    // the write pointer already points at.
    assign full    = (level == FULL_LVL);
    assign m_valid = (level != '0);
    assign pop     = m_valid && m_ready;
    assign push_ok = dump && (!full || pop);
    assign drop    = dump && full && !pop;

    // Storage, pointers, level and the sticky overflow flag. The memory is
    // reset so that m_data is never X, even before the first word arrives.
    // clr leaves the memory alone. m_data is don't-care while m_valid is
    // low, and the old contents are still defined values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= sat_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign m_data     = mem[rd_ptr];
    assign fifo_level = level;

`ifdef FIR_DECIM_SATCNT_EN
    // Counts every dump that was clipped, including words that were then
    // dropped on overflow. The count holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt <= '0;
        end else if (clr) begin
            sat_cnt <= '0;
        end else if (dump && clipped && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_decim_fifo.sv
// -----------------------------------------------------------------------------
// tb_fir_decim_fifo
//
// Self-checking bench for fir_decim_fifo with the default parameters
// (IN_W=10, OUT_W=8, DECIM=4, SHIFT=2, FIFO_DEPTH=8). A table of four-sample
// blocks with hand-computed words covers scaling, rounding and saturation.
// Hand-written sequences cover backpressure/overflow, full-plus-pop, clr and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fir_decim_fifo;

    logic              clk;
    logic              rst;
    logic signed [9:0] y_in;
    logic              en;
    logic              clr;
    logic signed [7:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [3:0]        fifo_level;
    logic              ovf;
`ifdef FIR_DECIM_SATCNT_EN
    logic [15:0]       sat_cnt;
    int                exp_sat;
`endif

    int tests_run;
    int tests_failed;

    typedef struct {
        int    s0;
        int    s1;
        int    s2;
        int    s3;
        int    exp;
        bit    clip;
        string name;
    } vec_t;

    vec_t vecs [12];

    fir_decim_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .y_in       (y_in),
        .en         (en),
        .clr        (clr),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .ovf        (ovf)
`ifdef FIR_DECIM_SATCNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs. Then advance past the next rising edge,
    // so the caller samples outputs 1 ns after that edge.
    task automatic applyStimulus(input int y, input bit e, input bit r, input bit c);
        y_in    = 10'(y);
        en      = e;
        m_ready = r;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Four enabled cycles of a constant value produce one dump.
    task automatic dumpConst(input int v, input bit ready_last);
        applyStimulus(v, 1'b1, 1'b0, 1'b0);
        applyStimulus(v, 1'b1, 1'b0, 1'b0);
        applyStimulus(v, 1'b1, 1'b0, 1'b0);
        applyStimulus(v, 1'b1, ready_last, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
`ifdef FIR_DECIM_SATCNT_EN
        exp_sat      = 0;
`endif
        // Expected word = sat((sum + 2) >>> 2), with floor on the shift.
        vecs[0]  = '{100, 100, 100, 100,  100, 1'b0, "scale100"};
        vecs[1]  = '{  1,   1,   0,   0,    1, 1'b0, "round_p2"};
        vecs[2]  = '{ -1,  -1,   0,   0,    0, 1'b0, "round_m2"};
        vecs[3]  = '{ -3,   0,   0,   0,   -1, 1'b0, "round_m3"};
        vecs[4]  = '{511, 511, 511, 511,  127, 1'b1, "sat_pos"};
        vecs[5]  = '{-512,-512,-512,-512,-128, 1'b1, "sat_neg"};
        vecs[6]  = '{  7,   0,   0,   0,    2, 1'b0, "round_p7"};
        vecs[7]  = '{ -6,   0,   0,   0,   -1, 1'b0, "round_m6"};
        vecs[8]  = '{200, 200, 200, 200,  127, 1'b1, "sat_pos200"};
        vecs[9]  = '{-130,-130,-130,-130,-128, 1'b1, "sat_neg130"};
        vecs[10] = '{127, 127, 127, 127,  127, 1'b0, "edge_max"};
        vecs[11] = '{-128,-128,-128,-128,-128, 1'b0, "edge_min"};

        // Reset state.
        rst     = 1'b0;
        y_in    = '0;
        en      = 1'b0;
        clr     = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_valid", m_valid, 0);
        checkOutput("rst_data", $signed(m_data), 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_ovf", ovf, 0);
`ifdef FIR_DECIM_SATCNT_EN
        checkOutput("rst_sat", sat_cnt, 0);
`endif
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        // Table: each block must give exactly one word that is visible for
        // one cycle (m_ready held high).
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].s0, 1'b1, 1'b1, 1'b0);
            applyStimulus(vecs[i].s1, 1'b1, 1'b1, 1'b0);
            applyStimulus(vecs[i].s2, 1'b1, 1'b1, 1'b0);
            checkOutput({vecs[i].name, "_pre"}, m_valid, 0);
            applyStimulus(vecs[i].s3, 1'b1, 1'b1, 1'b0);
            checkOutput({vecs[i].name, "_valid"}, m_valid, 1);
            checkOutput({vecs[i].name, "_data"}, $signed(m_data), vecs[i].exp);
            checkOutput({vecs[i].name, "_level"}, fifo_level, 1);
            applyStimulus(0, 1'b0, 1'b1, 1'b0);
            checkOutput({vecs[i].name, "_post"}, m_valid, 0);
`ifdef FIR_DECIM_SATCNT_EN
            if (vecs[i].clip) exp_sat++;
`endif
        end
`ifdef FIR_DECIM_SATCNT_EN
        checkOutput("table_sat", sat_cnt, exp_sat);
`endif

        // Backpressure: nine dumps into an eight-deep FIFO. The ninth is lost.
        for (int k = 1; k <= 9; k++) dumpConst(k, 1'b0);
        checkOutput("bp_level", fifo_level, 8);
        checkOutput("bp_ovf", ovf, 1);
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("bp_valid%0d", k), m_valid, 1);
            checkOutput($sformatf("bp_data%0d", k), $signed(m_data), k);
            applyStimulus(0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("bp_empty", m_valid, 0);
        checkOutput("bp_ovf_sticky", ovf, 1);

        // clr in the middle of a block with three words queued.
        for (int k = 1; k <= 3; k++) dumpConst(k, 1'b0);
        applyStimulus(10, 1'b1, 1'b0, 1'b0);
        applyStimulus(10, 1'b1, 1'b0, 1'b0);
        applyStimulus(10, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_level", fifo_level, 0);
        checkOutput("clr_valid", m_valid, 0);
        checkOutput("clr_ovf", ovf, 0);
`ifdef FIR_DECIM_SATCNT_EN
        checkOutput("clr_sat", sat_cnt, 0);
`endif
        dumpConst(50, 1'b0);
        checkOutput("clr_after_valid", m_valid, 1);
        checkOutput("clr_after_data", $signed(m_data), 50);
        checkOutput("clr_after_level", fifo_level, 1);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        checkOutput("clr_after_drain", fifo_level, 0);

        // Full FIFO with a pop on the same edge as the ninth dump.
        for (int k = 1; k <= 8; k++) dumpConst(k, 1'b0);
        checkOutput("fp_level8", fifo_level, 8);
        dumpConst(9, 1'b1);
        checkOutput("fp_level", fifo_level, 8);
        checkOutput("fp_ovf", ovf, 0);
        for (int k = 2; k <= 9; k++) begin
            checkOutput($sformatf("fp_data%0d", k), $signed(m_data), k);
            applyStimulus(0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("fp_empty", m_valid, 0);

        // Asynchronous reset between edges, with the FIFO overflowed and a
        // block half accumulated.
        for (int k = 1; k <= 9; k++) dumpConst(k, 1'b0);
        applyStimulus(7, 1'b1, 1'b0, 1'b0);
        applyStimulus(7, 1'b1, 1'b0, 1'b0);
        checkOutput("ar_ovf_before", ovf, 1);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("ar_valid", m_valid, 0);
        checkOutput("ar_data", $signed(m_data), 0);
        checkOutput("ar_level", fifo_level, 0);
        checkOutput("ar_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dumpConst(50, 1'b0);
        checkOutput("ar_after_data", $signed(m_data), 50);
        checkOutput("ar_after_level", fifo_level, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
